// File: rtl/perf_csr_bank.sv
// Performance counter CSR bank: 64-bit mcycle/minstret/mhpmcounterN with event
// selectors and inhibit mask, exposed as RV32 CSRs with a registered response.
module perf_csr_bank #(
  parameter int NUM_HPM    = 3,
  parameter int NUM_EVENTS = 5,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_EVENTS-1:0] events_i,
  input  logic                  csr_req_valid,
  input  logic [11:0]           csr_addr,
  input  logic                  csr_we,
  input  logic [31:0]           csr_wdata,
  output logic                  csr_rsp_valid,
  output logic [31:0]           csr_rdata,
  output logic                  csr_rsp_illegal
);
  // Slot 0 = mcycle, slot 1 = minstret, slot s>=2 = mhpmcounter(s+1).
  localparam int              NSLOT    = NUM_HPM + 2;
  localparam int              LAST     = NUM_HPM + 2;
  localparam logic [4:0]      LAST5    = 5'(LAST);
  localparam logic [32:0]     LOW_ONES = (33'h1 << (LAST + 1)) - 33'h1;
  localparam logic [31:0]     INH_MASK = LOW_ONES[31:0] & 32'hFFFF_FFFD;

  logic [4:0] idx;
  logic [6:0] grp;
  logic       hi;
  logic       idx_cnt, is_mcnt, is_ucnt, is_inh, is_evt, illegal, wr_en;

  assign idx     = csr_addr[4:0];
  assign grp     = csr_addr[11:5];
  assign hi      = csr_addr[7];
  assign idx_cnt = (idx == 5'd0) || (idx == 5'd2) || ((idx >= 5'd3) && (idx <= LAST5));
  assign is_mcnt = ((grp == 7'h58) || (grp == 7'h5C)) && idx_cnt;
  assign is_ucnt = ((grp == 7'h60) || (grp == 7'h64)) && idx_cnt;
  assign is_inh  = (grp == 7'h19) && (idx == 5'd0);
  assign is_evt  = (grp == 7'h19) && (idx >= 5'd3) && (idx <= LAST5);
  assign illegal = !(is_mcnt || is_ucnt || is_inh || is_evt) || (csr_we && is_ucnt);
  assign wr_en   = csr_req_valid && csr_we && !illegal;

  logic [31:0]          inh_q, inh_d;
  logic [CNT_WIDTH-1:0] cnt_all [NSLOT];
  logic [4:0]           evt_all [NSLOT];

  assign inh_d = (wr_en && is_inh) ? (csr_wdata & INH_MASK) : inh_q;

  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
    localparam int CSR_N = (gi == 0) ? 0 : gi + 1;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 inc, wr_cnt;

    assign wr_cnt = wr_en && is_mcnt && (idx == 5'(CSR_N));

    if (gi == 0) begin : g_cycle
      assign inc          = !inh_q[0];
      assign evt_all[gi]  = '0;
    end else if (gi == 1) begin : g_instret
      assign inc          = events_i[0] && !inh_q[2];
      assign evt_all[gi]  = '0;
    end else begin : g_hpm
      logic [4:0] evt_q, evt_d;
      logic       hit;
      // Selector values outside 1..NUM_EVENTS never match, so they never count.
      always_comb begin
        hit = 1'b0;
        for (int e = 0; e < NUM_EVENTS; e++) begin
          if ((evt_q == 5'(e + 1)) && events_i[e]) hit = 1'b1;
        end
      end
      assign inc   = hit && !inh_q[CSR_N];
      assign evt_d = (wr_en && is_evt && (idx == 5'(CSR_N))) ? csr_wdata[4:0] : evt_q;
      always_ff @(posedge clk) begin
        if (reset) evt_q <= '0;
        else       evt_q <= evt_d;
      end
      assign evt_all[gi] = evt_q;
    end

    // A write to either half suppresses the whole counter's increment this cycle.
    always_comb begin
      cnt_d = cnt_q;
      if (wr_cnt) begin
        if (hi) cnt_d[CNT_WIDTH-1:32] = csr_wdata;
        else    cnt_d[31:0]           = csr_wdata;
      end else if (inc) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end

    assign cnt_all[gi] = cnt_q;
  end

  logic [CNT_WIDTH-1:0] cnt_sel;
  logic [4:0]           evt_sel;
  logic [31:0]          rd_val;

  always_comb begin
    cnt_sel = '0;
    evt_sel = '0;
    for (int s = 0; s < NSLOT; s++) begin
      if (idx == 5'((s == 0) ? 0 : s + 1)) begin
        cnt_sel = cnt_all[s];
        evt_sel = evt_all[s];
      end
    end
    rd_val = '0;
    if (illegal)     rd_val = '0;
    else if (is_inh) rd_val = inh_q;
    else if (is_evt) rd_val = {27'b0, evt_sel};
    else             rd_val = hi ? cnt_sel[CNT_WIDTH-1:32] : cnt_sel[31:0];
  end

  logic        rsp_valid_q, rsp_valid_d, rsp_illegal_q, rsp_illegal_d;
  logic [31:0] rdata_q, rdata_d;

  assign rsp_valid_d   = csr_req_valid;
  assign rsp_illegal_d = csr_req_valid && illegal;
  assign rdata_d       = csr_req_valid ? rd_val : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      inh_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
      rdata_q       <= '0;
    end else begin
      inh_q         <= inh_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_illegal_q <= rsp_illegal_d;
      rdata_q       <= rdata_d;
    end
  end

  // Reset raised while a response is pending cancels it immediately.
  assign csr_rsp_valid   = rsp_valid_q && !reset;
  assign csr_rdata       = rdata_q;
  assign csr_rsp_illegal = rsp_illegal_q;
endmodule

// File: tb/tb_perf_csr_bank.sv
// Randomized + directed bench for perf_csr_bank against an array-based CSR model.
module tb_perf_csr_bank;
  localparam int H    = 3;
  localparam int NE   = 5;
  localparam int LAST = 2 + H;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NE-1:0] events_i = '0;
  logic          csr_req_valid = 1'b0;
  logic [11:0]   csr_addr = '0;
  logic          csr_we = 1'b0;
  logic [31:0]   csr_wdata = '0;
  logic          csr_rsp_valid;
  logic [31:0]   csr_rdata;
  logic          csr_rsp_illegal;

  perf_csr_bank #(.NUM_HPM(H), .NUM_EVENTS(NE), .CNT_WIDTH(64)) dut (
    .clk(clk), .reset(reset), .events_i(events_i),
    .csr_req_valid(csr_req_valid), .csr_addr(csr_addr), .csr_we(csr_we),
    .csr_wdata(csr_wdata), .csr_rsp_valid(csr_rsp_valid),
    .csr_rdata(csr_rdata), .csr_rsp_illegal(csr_rsp_illegal)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: CSR number -> 64-bit counter value.
  logic [63:0] m_cnt [0:31];
  logic [4:0]  m_evt [0:31];
  logic [31:0] m_inh;

  function automatic void m_reset();
    for (int n = 0; n < 32; n++) begin
      m_cnt[n] = '0;
      m_evt[n] = '0;
    end
    m_inh = '0;
  endfunction

  function automatic bit m_is_cnt(input int n);
    return (n == 0) || (n == 2) || (n >= 3 && n <= LAST);
  endfunction

  function automatic void m_decode(input int a, input bit we, output bit ill, output logic [31:0] d);
    int n, base;
    ill = 1'b1;
    d = '0;
    n = a % 32;
    base = a - n;
    if (a == 'h320) begin
      ill = 1'b0;
      d = m_inh;
    end else if (a >= 'h323 && a <= 'h320 + LAST) begin
      ill = 1'b0;
      d = {27'b0, m_evt[a - 'h320]};
    end else if ((base == 'hB00 || base == 'hB80 || base == 'hC00 || base == 'hC80) && m_is_cnt(n)) begin
      if (!(we && base >= 'hC00)) begin
        ill = 1'b0;
        d = (base == 'hB80 || base == 'hC80) ? m_cnt[n][63:32] : m_cnt[n][31:0];
      end
    end
  endfunction

  function automatic void m_step(input bit req, input int a, input bit we, input logic [31:0] wd,
                                 input logic [4:0] ev);
    logic [63:0] nc [0:31];
    bit          ill, inc;
    logic [31:0] dummy;
    int          sel;
    m_decode(a, we, ill, dummy);
    for (int n = 0; n < 32; n++) nc[n] = m_cnt[n];
    for (int n = 0; n <= LAST; n++) begin
      if (n == 1) continue;
      sel = int'(m_evt[n]);
      if (n == 0)      inc = !m_inh[0];
      else if (n == 2) inc = ev[0] && !m_inh[2];
      else             inc = (sel >= 1) && (sel <= NE) && ev[sel-1] && !m_inh[n];
      if (inc) nc[n] = m_cnt[n] + 64'd1;
    end
    if (req && we && !ill) begin
      if (a == 'h320) m_inh = wd & 32'h0000_003D;
      else if (a >= 'h323 && a <= 'h320 + LAST) m_evt[a - 'h320] = wd[4:0];
      else if (a < 'hB80) nc[a % 32] = {m_cnt[a % 32][63:32], wd};
      else                nc[a % 32] = {wd, m_cnt[a % 32][31:0]};
    end
    for (int n = 0; n < 32; n++) m_cnt[n] = nc[n];
  endfunction

  task automatic xact(input bit req, input logic [11:0] addr, input bit we, input logic [31:0] wd,
                      input logic [4:0] ev, output logic [31:0] rd);
    bit          e_ill;
    logic [31:0] e_d;
    m_decode(int'(addr), we, e_ill, e_d);
    csr_req_valid = req;
    csr_addr      = addr;
    csr_we        = we;
    csr_wdata     = wd;
    events_i      = ev;
    @(posedge clk);
    m_step(req, int'(addr), we, wd, ev);
    #1;
    rd = csr_rdata;
    chk($sformatf("rsp_valid@%h", addr), csr_rsp_valid, req);
    if (req) begin
      chk($sformatf("rdata@%h", addr), csr_rdata, e_d);
      chk($sformatf("illegal@%h", addr), csr_rsp_illegal, e_ill);
      $display("xact addr=%h we=%0d wdata=%h ev=%b -> rdata=%h illegal=%0d",
               addr, we, wd, ev, csr_rdata, csr_rsp_illegal);
    end
    csr_req_valid = 1'b0;
    csr_we        = 1'b0;
    events_i      = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    csr_req_valid = 1'b1;  // dropped: presented during reset
    csr_addr = 12'hB00;
    @(posedge clk);
    m_reset();
    #1;
    csr_req_valid = 1'b0;
    chk("reset_valid", csr_rsp_valid, 0);
    chk("reset_rdata", csr_rdata, 0);
    chk("reset_illegal", csr_rsp_illegal, 0);
    reset = 1'b0;
    @(posedge clk);
    m_step(1'b0, 0, 1'b0, '0, '0);
    #1;
    chk("reset_req_dropped", csr_rsp_valid, 0);
  endtask

  logic [11:0] addr_pool [0:15];

  initial begin
    logic [31:0] rd;
    addr_pool = '{12'h320, 12'h323, 12'h324, 12'h325, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                  12'hB03, 12'hB84, 12'hC00, 12'hC85, 12'h321, 12'hB01, 12'hB06, 12'h7FF};
    do_reset();
    // The dropped-request check consumed one idle cycle; nine more make ten.
    for (int i = 0; i < 9; i++) xact(1'b0, 12'h0, 1'b0, '0, '0, rd);
    xact(1'b1, 12'hB00, 1'b0, '0, '0, rd);
    chk("mcycle_after_10", rd, 32'd10);

    xact(1'b1, 12'hB00, 1'b1, 32'hFFFF_FFFF, '0, rd);
    xact(1'b1, 12'hB80, 1'b1, 32'h0, '0, rd);
    xact(1'b0, 12'h0, 1'b0, '0, '0, rd);
    xact(1'b1, 12'hB80, 1'b0, '0, '0, rd);
    chk("mcycle_carry_hi", rd, 32'd1);
    xact(1'b1, 12'hB00, 1'b0, '0, '0, rd);

    xact(1'b1, 12'h320, 1'b1, 32'h0, '0, rd);
    xact(1'b1, 12'h323, 1'b1, 32'h2, '0, rd);
    for (int i = 0; i < 4; i++) xact(1'b0, 12'h0, 1'b0, '0, 5'b00010, rd);
    xact(1'b1, 12'hB03, 1'b0, '0, '0, rd);
    chk("hpm3_count4", rd, 32'd4);
    xact(1'b1, 12'h320, 1'b1, 32'h8, '0, rd);
    for (int i = 0; i < 3; i++) xact(1'b0, 12'h0, 1'b0, '0, 5'b00010, rd);
    xact(1'b1, 12'hB03, 1'b0, '0, '0, rd);
    chk("hpm3_inhibited", rd, 32'd4);

    xact(1'b1, 12'hC00, 1'b1, 32'h1234, '0, rd);
    chk("wr_shadow_illegal", csr_rsp_illegal, 1);
    xact(1'b1, 12'h7FF, 1'b0, '0, '0, rd);
    chk("unmapped_illegal", csr_rsp_illegal, 1);
    xact(1'b1, 12'hB00, 1'b0, '0, '0, rd);

    xact(1'b1, 12'hB02, 1'b1, 32'h100, 5'b00001, rd);
    xact(1'b1, 12'hB02, 1'b0, '0, '0, rd);
    chk("minstret_write_wins", rd, 32'h100);

    for (int i = 0; i < 300; i++) begin
      bit          req, we;
      logic [11:0] a;
      logic [31:0] wd;
      req = ($urandom_range(0, 9) < 7);
      we  = ($urandom_range(0, 9) < 3);
      a   = ($urandom_range(0, 7) == 0) ? 12'($urandom) : addr_pool[$urandom_range(0, 15)];
      wd  = $urandom;
      if (a == 12'h320) wd = wd & 32'h0000_0015;  // keep most counters live
      if (a >= 12'h323 && a <= 12'h325) wd = {wd[31:3], 3'($urandom_range(0, 6))};
      xact(req, a, we, wd, 5'($urandom), rd);
    end

    csr_req_valid = 1'b1;
    csr_addr = 12'hB00;
    csr_we = 1'b0;
    @(posedge clk);
    #1;
    csr_req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("cancel_valid_now", csr_rsp_valid, 0);
    @(posedge clk);
    m_reset();
    #1;
    chk("cancel_valid_next", csr_rsp_valid, 0);
    reset = 1'b0;
    xact(1'b1, 12'hB00, 1'b0, '0, '0, rd);
    chk("post_reset_mcycle", rd, 32'd0);
    xact(1'b1, 12'hB02, 1'b0, '0, '0, rd);
    chk("post_reset_minstret", rd, 32'd0);
    xact(1'b1, 12'hB03, 1'b0, '0, '0, rd);
    xact(1'b1, 12'hB84, 1'b0, '0, '0, rd);
    xact(1'b1, 12'hB05, 1'b0, '0, '0, rd);
    xact(1'b1, 12'h320, 1'b0, '0, '0, rd);
    xact(1'b1, 12'h324, 1'b0, '0, '0, rd);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/perf_csr_bank.md
Name: perf_csr_bank

Overview:
- Downstream consumer of the core's performance events: holds architectural 64-bit counters (mcycle, minstret, mhpmcounter3..) plus their event selectors and inhibit mask.
- Exposes them to the CSR unit as 32-bit CSR reads and writes (Zicntr/Zihpm, RV32).
- Inputs are per-cycle event pulses from the pipeline.
- The CSR unit issues at most one request per cycle and receives a registered response one cycle later.

Parameters:
- NUM_HPM, 3: number of programmable counters, mhpmcounter3 .. mhpmcounter(2+NUM_HPM); legal range 1..29.
- NUM_EVENTS, 5: width of the event vector.
- CNT_WIDTH, 64: counter width; fixed at 64 for RV32 low/high split.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- events_i  in  NUM_EVENTS  per-cycle pulses: [0] instruction_retired, [1] branch_taken, [2] branch_mispredicted, [3] load_use_stall, [4] div_stall
- csr_req_valid  in  1  request present this cycle
- csr_addr  in  12  CSR address
- csr_we  in  1  write request; 0 = read only
- csr_wdata  in  32  write data
- csr_rsp_valid  out  1  response valid; asserted the cycle after the request
- csr_rdata  out  32  read data (pre-write value)
- csr_rsp_illegal  out  1  address unmapped or write to read-only CSR

Behaviour:
- Reset (clk edge with reset=1):
  - All counters, mhpmevent* and mcountinhibit go to 0.
  - csr_rsp_valid=0, csr_rdata=0, csr_rsp_illegal=0.
  - A request presented in the reset cycle is dropped; no response is produced.
- Address map, machine read/write:
  - mcountinhibit 0x320.
  - mhpmeventN 0x320+N.
  - mcycle 0xB00/0xB80 (low/high).
  - minstret 0xB02/0xB82.
  - mhpmcounterN 0xB00+N/0xB80+N, for N = 3..2+NUM_HPM.
- Address map, user read-only shadows:
  - cycle 0xC00/0xC80, instret 0xC02/0xC82, hpmcounterN 0xC00+N/0xC80+N.
  - These return the same values as the machine versions.
- Any other address is illegal. A write to 0xCxx is illegal.
- Illegal response: csr_rsp_illegal=1, csr_rdata=0, no state change.
- Increment rules, evaluated every cycle not overridden by a write:
  - mcycle: +1 when !mcountinhibit[0].
  - minstret: +1 when events_i[0] && !mcountinhibit[2].
  - mhpmcounterN: +1 when sel=mhpmeventN[4:0], 1<=sel<=NUM_EVENTS, events_i[sel-1]=1 and !mcountinhibit[N].
  - sel=0 or sel>NUM_EVENTS means never count.
- Counter width and wrap: counters are 64-bit and wrap 0xFFFF_FFFF_FFFF_FFFF -> 0. The carry from the low to the high half happens in the same cycle.
- mhpmeventN register:
  - Implements bits [4:0]; bits [31:5] read 0 and writes to them are ignored.
- mcountinhibit register:
  - Implements bits 0, 2 and 3..2+NUM_HPM.
  - Bit 1 and bits above 2+NUM_HPM read 0; writes to them are ignored.
- Request timing:
  - A request is accepted in any cycle with csr_req_valid=1; there is no backpressure.
  - Response fields are registered and valid exactly one cycle later, for exactly one cycle.
- Read value:
  - csr_rdata is the value the CSR held at the start of the request cycle, before that cycle's write or increment (CSRRW semantics).
- Write timing and priority:
  - A write takes effect at the end of the request cycle.
  - Write to a counter half: that half = csr_wdata and the other half is unchanged. That cycle's increment is suppressed for the whole counter, including carry into the untouched half.
  - A write to mcountinhibit or mhpmeventN affects counting from the next cycle. In the write cycle itself, the old values apply.
- Back-to-back requests are independent; each produces its own response one cycle later.
- Reset asserted while a response is pending:
  - The response is cancelled: csr_rsp_valid=0 on the following cycle.

Test Plan:
- Reset, then idle 10 cycles, then read 0xB00 -> rsp next cycle with rdata=10 (cycle count since reset released, value at request cycle); rsp_illegal=0.
- Write mcycle low=0xFFFF_FFFF and high=0 on consecutive cycles, then read 0xB80 two cycles after the last write -> rdata=1 (carry propagated); low read gives small wrapped value.
- Write mhpmevent3=2 and pulse events_i[1] 4 times with mcountinhibit=0 -> read 0xB03 returns 4. Then set mcountinhibit[3]=1 and pulse 3 more times -> count stays 4.
- Write to 0xC00 and read 0x7FF -> both give rsp_illegal=1, rdata=0; mcycle is unchanged apart from normal counting.
- In the same cycle, write minstret low=0x100 while events_i[0]=1 -> the following read returns 0x100 (write wins, increment dropped).
- Issue a read request and assert reset in the next cycle -> no csr_rsp_valid; all counters read 0 after reset.
